// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the MIPS E stage: owns HI/LO and sequences multi-cycle mult/div.
// Optional flush support is enabled with `define MDU_CANCEL_EN (adds the E_cancel input).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
`ifdef MDU_CANCEL_EN
    input  logic        E_cancel,
`endif
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_MDout
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic        r_pend_ok;
    logic        r_busy;

    logic        w_cancel;
    logic        w_is_mul, w_is_div;
    logic [63:0] w_a_ext, w_b_ext, w_prod;
    logic        w_a_neg, w_b_neg, w_div_zero;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q, w_r;

`ifdef MDU_CANCEL_EN
    assign w_cancel = E_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_is_mul = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
    assign w_is_div = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
    assign E_start  = (r_state == S_IDLE) && (w_is_mul || w_is_div) && !w_cancel;
    assign E_busy   = r_busy;

    // The low 64 bits of a 64x64 product are correct for both signednesses once operands are extended.
    assign w_a_ext = {{32{(E_MDOp == OP_MULT) & E_A[31]}}, E_A};
    assign w_b_ext = {{32{(E_MDOp == OP_MULT) & E_B[31]}}, E_B};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed division on magnitudes avoids the 0x80000000 / -1 overflow and keeps remainder sign = dividend sign.
    assign w_a_neg    = (E_MDOp == OP_DIV) & E_A[31];
    assign w_b_neg    = (E_MDOp == OP_DIV) & E_B[31];
    assign w_div_zero = (E_B == 32'd0);
    assign w_a_mag    = w_a_neg ? (~E_A + 32'd1) : E_A;
    assign w_b_mag    = w_div_zero ? 32'd1 : (w_b_neg ? (~E_B + 32'd1) : E_B);
    assign w_q_mag    = w_a_mag / w_b_mag;
    assign w_r_mag    = w_a_mag % w_b_mag;
    assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        E_MDout = 32'd0;
        if (E_MDOp == OP_MFHI)      E_MDout = r_hi;
        else if (E_MDOp == OP_MFLO) E_MDout = r_lo;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (E_start) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        if (w_is_mul) begin
                            r_pend_hi <= w_prod[63:32];
                            r_pend_lo <= w_prod[31:0];
                            r_pend_ok <= 1'b1;
                            r_cnt     <= MULT_N;
                        end else begin
                            r_pend_hi <= w_r;
                            r_pend_lo <= w_q;
                            r_pend_ok <= !w_div_zero;
                            r_cnt     <= DIV_N;
                        end
                    end else if (E_MDOp == OP_MTHI) begin
                        r_hi <= E_A;
                    end else if (E_MDOp == OP_MTLO) begin
                        r_lo <= E_A;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_pend_ok) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against an arithmetic reference model.
// Build with +define+MDU_CANCEL_EN to also exercise the cancel input.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A, E_B;
    logic        cancel_in;
    logic        E_start, E_busy;
    logic [31:0] E_MDout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural HI/LO, cycles left in flight, and the result to commit.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pok;
    int          m_left;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDOp  (E_MDOp),
        .E_A     (E_A),
        .E_B     (E_B),
`ifdef MDU_CANCEL_EN
        .E_cancel(cancel_in),
`endif
        .E_start (E_start),
        .E_busy  (E_busy),
        .E_MDout (E_MDout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rst, input logic cn);
        logic [31:0] exp_out;
        logic        exp_start;
        E_MDOp = op; E_A = a; E_B = b; reset = rst; cancel_in = cn;
        @(negedge clk);
        exp_start = (m_left == 0) && (op >= 4'd1) && (op <= 4'd4) && !cn;
        exp_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        check("start", {31'd0, E_start}, {31'd0, exp_start});
        check("busy",  {31'd0, E_busy},  {31'd0, m_left > 0});
        check("mdout", E_MDout, exp_out);
    endtask

    task automatic advance();
        longint      sa, sb;
        logic [63:0] p;
        @(posedge clk);
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pok = 0;
        end else if (cancel_in) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        end else begin
            case (E_MDOp)
                4'd1, 4'd2: begin
                    if (E_MDOp == 4'd1) p = 64'(longint'($signed(E_A)) * longint'($signed(E_B)));
                    else                p = {32'd0, E_A} * {32'd0, E_B};
                    m_phi = p[63:32]; m_plo = p[31:0]; m_pok = 1; m_left = MULT_N;
                end
                4'd3, 4'd4: begin
                    sa = (E_MDOp == 4'd3) ? longint'($signed(E_A)) : longint'({32'd0, E_A});
                    sb = (E_MDOp == 4'd3) ? longint'($signed(E_B)) : longint'({32'd0, E_B});
                    m_pok = (sb != 0);
                    if (m_pok) begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
                    m_left = DIV_N;
                end
                4'd7: m_hi = E_A;
                4'd8: m_lo = E_A;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b, 1'b0, 1'b0);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0);
    endtask

    // Reads HI then LO and also compares them to hand-derived constants.
    task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        check({tag, "_hi"}, E_MDout, hi);
        advance();
        drive(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        check({tag, "_lo"}, E_MDout, lo);
        advance();
    endtask

    initial begin
        E_MDOp = 0; E_A = 0; E_B = 0; cancel_in = 0; reset = 1;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_hilo("reset", 32'd0, 32'd0);

        step(4'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_N);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        step(4'd4, 32'd7, 32'd2);
        idle(DIV_N);
        expect_hilo("divu", 32'd1, 32'd3);
        step(4'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        step(4'd7, 32'h1234_5678, 32'd0);
        step(4'd3, 32'd5, 32'd0);
        idle(DIV_N);
        expect_hilo("div0", 32'h1234_5678, 32'hFFFF_FFFD);

        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        expect_hilo("ovf", 32'd0, 32'h8000_0000);

        step(4'd1, 32'd3, 32'd4);
        step(4'd8, 32'h0000_AAAA, 32'd0);
        drive(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        check("busy_mflo", E_MDout, 32'h8000_0000);
        advance();
        drive(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        advance();
        expect_hilo("rst_mid", 32'd0, 32'd0);

        step(4'd2, 32'h0001_0000, 32'h0001_0000);
        idle(MULT_N);
        step(4'd4, 32'd100, 32'd7);
        idle(DIV_N);
        expect_hilo("b2b", 32'd2, 32'd14);

`ifdef MDU_CANCEL_EN
        step(4'd7, 32'd11, 32'd0);
        step(4'd8, 32'd22, 32'd0);
        step(4'd1, 32'd5, 32'd6);
        idle(2);
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        advance();
        idle(1);
        expect_hilo("cancel", 32'd11, 32'd22);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            logic        rs, cn;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            b  = ($urandom_range(0, 9) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            rs = ($urandom_range(0, 199) == 0);
            cn = 1'b0;
`ifdef MDU_CANCEL_EN
            cn = ($urandom_range(0, 49) == 0);
`endif
            drive(4'($urandom_range(0, 15)), a, b, rs, cn);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
